// File: rtl/envelope_shift_gen_pkg.sv
// Shared types and constants for the ADSR envelope and its shift-code encoder.
// Latency: n/a (declarations only). Backpressure: n/a.
package envelope_shift_gen_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int         LEVEL_MAX  = 16;
  localparam logic [3:0] SHIFT_ZERO = 4'd15;  // shift large enough to mute the term
  localparam logic [3:0] NO_TERM    = 4'd0;

endpackage

// File: rtl/envelope_shift_gen_gain_to_shifts.sv
// Purpose: map a 0..16 gain level onto four power-of-two shift terms.
// Latency: combinational. Backpressure: none, pure function of level.
module gain_to_shifts (
  input  logic [4:0] level,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d
);
  import envelope_shift_gen_pkg::*;

  logic [3:0] slot [4];
  logic [2:0] n;

  // Bit k of the level carries weight 2^(k-4), i.e. shift 4-k; fill slots MSB first
  always_comb begin
    for (int i = 0; i < 4; i++) slot[i] = NO_TERM;
    n = 3'd0;
    if (level >= 5'(LEVEL_MAX)) begin
      slot[0] = 4'd0;
    end else if (level == 5'd0) begin
      slot[0] = SHIFT_ZERO;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (level[k]) begin
          slot[n[1:0]] = 4'(4 - k);
          n = n + 3'd1;
        end
      end
    end
  end

  assign a = slot[0];
  assign b = slot[1];
  assign c = slot[2];
  assign d = slot[3];

endmodule

// File: rtl/envelope_shift_gen.sv
// Purpose: per-voice ADSR level stepper producing registered shift codes for the scaler.
// Latency: level/state update on the edge; a/b/c/d follow level one clock later. Backpressure: none.
module envelope_shift_gen #(
  parameter int RATE_W    = 16,
  parameter int LEVEL_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_sample,
  input  logic              note_on,
  input  logic              note_off,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [RATE_W-1:0] release_rate,
  input  logic [4:0]        sustain_level,
  output logic [3:0]        a,
  output logic [3:0]        b,
  output logic [3:0]        c,
  output logic [3:0]        d,
  output logic [4:0]        level,
  output logic [2:0]        state,
  output logic              active
);
  import envelope_shift_gen_pkg::*;

  localparam logic [4:0] LVL_FULL = 5'(LEVEL_MAX);

  env_state_t        state_q, state_d;
  logic [4:0]        level_q, level_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [RATE_W-1:0] rate_sel, rate_eff;
  logic [4:0]        sus;
  logic              at_end;
  logic [3:0]        a_d, b_d, c_d, d_d;

  assign sus = (sustain_level > LVL_FULL) ? LVL_FULL : sustain_level;

  always_comb begin
    rate_sel = release_rate;
    if (state_q == ATTACK)     rate_sel = attack_rate;
    else if (state_q == DECAY) rate_sel = decay_rate;
  end

  // A zero rate behaves like one step per strobe
  assign rate_eff = (rate_sel == '0) ? RATE_W'(1) : rate_sel;
  assign at_end   = (cnt_q == rate_eff - RATE_W'(1));

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (note_on) begin
      state_d = ATTACK;
      cnt_d   = '0;
    end else if (note_off && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          level_d = '0;
          cnt_d   = '0;
        end
        ATTACK: begin
          if (new_sample) begin
            if (at_end) begin
              cnt_d = '0;
              if (level_q >= LVL_FULL - 5'd1) begin
                level_d = LVL_FULL;
                state_d = (sus == LVL_FULL) ? SUSTAIN : DECAY;
              end else begin
                level_d = level_q + 5'd1;
              end
            end else begin
              cnt_d = cnt_q + RATE_W'(1);
            end
          end
        end
        DECAY: begin
          if (level_q <= sus) begin
            state_d = SUSTAIN;
            cnt_d   = '0;
          end else if (new_sample) begin
            if (at_end) begin
              cnt_d   = '0;
              level_d = level_q - 5'd1;
              if (level_q - 5'd1 <= sus) state_d = SUSTAIN;
            end else begin
              cnt_d = cnt_q + RATE_W'(1);
            end
          end
        end
        SUSTAIN: cnt_d = '0;
        RELEASE: begin
          if (level_q == 5'd0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (new_sample) begin
            if (at_end) begin
              cnt_d   = '0;
              level_d = level_q - 5'd1;
              if (level_q == 5'd1) state_d = IDLE;
            end else begin
              cnt_d = cnt_q + RATE_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  gain_to_shifts u_codes (
    .level (level_q),
    .a     (a_d),
    .b     (b_d),
    .c     (c_d),
    .d     (d_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      a       <= SHIFT_ZERO;
      b       <= NO_TERM;
      c       <= NO_TERM;
      d       <= NO_TERM;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      a       <= a_d;
      b       <= b_d;
      c       <= c_d;
      d       <= d_d;
    end
  end

  assign level  = level_q;
  assign state  = state_q;
  assign active = (state_q != IDLE);

endmodule
